fp_to_int_conv: RTL

FP_TO_INT_CONV -- requirements
Module: fp_to_int_conv

---
 rtl/fp_to_int_conv.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_to_int_conv.sv
// Multi-cycle float-to-integer converter: unpack, align, round, then hold the
// result until the consumer takes it. Saturates with an invalid flag on overflow.
module fp_to_int_conv #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_float,
  input  logic [2:0]           in_rm,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_W-1:0]     out_int,
  output logic                 out_nv,
  output logic                 out_nx
);

  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = (EXP_W + 2 > 9) ? EXP_W + 2 : 9;
  localparam int SW   = (INT_W > MAN_W + 1) ? INT_W : MAN_W + 1;
  localparam int RW   = 2 * MAN_W + 3;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ROUND, S_OUT} state_e;
  typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_NAN} class_e;

  state_e                state_q, state_d;
  logic [FP_W-1:0]       op_q, op_d;
  logic [2:0]            rm_q, rm_d;
  logic                  is_signed_q, is_signed_d;
  class_e                cls_q, cls_d;
  logic [MAN_W:0]        sig_q, sig_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [INT_W-1:0]      mag_q, mag_d;
  logic                  rnd_q, rnd_d;
  logic                  stk_q, stk_d;
  logic                  big_q, big_d;
  logic [INT_W-1:0]      out_int_q, out_int_d;
  logic                  out_nv_q, out_nv_d;
  logic                  out_nx_q, out_nx_d;

  logic                  op_sign;
  logic [EXP_W-1:0]      op_exp;
  logic [MAN_W-1:0]      op_man;
  int                    exp_i;
  logic [SW-1:0]         ext;
  logic [RW-1:0]         rv;
  logic                  inc;
  logic [INT_W:0]        rounded;
  logic [INT_W-1:0]      pos_max;
  logic [INT_W-1:0]      neg_sat;
  logic                  ovf;
  logic                  uneg;

  assign op_sign = op_q[FP_W-1];
  assign op_exp  = op_q[FP_W-2:MAN_W];
  assign op_man  = op_q[MAN_W-1:0];
  assign exp_i   = int'(exp_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_UNPACK;
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ROUND;
      S_ROUND:  state_d = S_OUT;
      S_OUT:    if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
  end

  assign out_int = out_int_q;
  assign out_nv  = out_nv_q;
  assign out_nx  = out_nx_q;

  // Capture, classify and align: each stage only rewrites its own registers.
  always_comb begin
    // NOTE: every *_d defaults to its *_q (and temporaries to zero) first, so no path can infer a latch.
    op_d        = op_q;
    rm_d        = rm_q;
    is_signed_d = is_signed_q;
    cls_d       = cls_q;
    sig_d       = sig_q;
    exp_d       = exp_q;
    mag_d       = mag_q;
    rnd_d       = rnd_q;
    stk_d       = stk_q;
    big_d       = big_q;
    ext         = '0;
    rv          = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d        = in_float;
          rm_d        = in_rm;
          is_signed_d = in_signed;
        end
      end
      S_UNPACK: begin
        if (op_exp == '0) begin
          cls_d = (op_man == '0) ? C_ZERO : C_SUB;
          sig_d = {1'b0, op_man};
          exp_d = EW'(1 - BIAS);
        end else if (&op_exp) begin
          cls_d = (op_man == '0) ? C_INF : C_NAN;
          sig_d = {1'b0, op_man};
          exp_d = '0;
        end else begin
          cls_d = C_NORM;
          sig_d = {1'b1, op_man};
          exp_d = EW'({{(EW-EXP_W){1'b0}}, op_exp}) - EW'(BIAS);
        end
      end
      S_ALIGN: begin
        mag_d = '0;
        rnd_d = 1'b0;
        stk_d = 1'b0;
        big_d = 1'b0;
        if (cls_q == C_NORM || cls_q == C_SUB) begin
          if (exp_i >= INT_W) begin
            big_d = 1'b1;
          end else if (exp_i >= MAN_W) begin
            ext   = SW'(sig_q) << (exp_i - MAN_W);
            mag_d = ext[INT_W-1:0];
          end else if (MAN_W - exp_i > MAN_W + 1) begin
            // Everything lies below the round position: only sticky survives.
            stk_d = |sig_q;
          end else begin
            rv    = {sig_q, {(MAN_W+2){1'b0}}} >> (MAN_W - exp_i);
            ext   = SW'(rv[RW-1 -: MAN_W+1]);
            mag_d = ext[INT_W-1:0];
            rnd_d = rv[MAN_W+1];
            stk_d = |rv[MAN_W:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Rounding, range check and saturation; the result registers hold through OUT.
  always_comb begin
    out_int_d = out_int_q;
    out_nv_d  = out_nv_q;
    out_nx_d  = out_nx_q;
    case (rm_q)
      3'b001:  inc = (rnd_q | stk_q) & ~op_sign;
      3'b010:  inc = (rnd_q | stk_q) & op_sign;
      3'b011:  inc = rnd_q & (stk_q | mag_q[0]);
      3'b100:  inc = rnd_q;
      default: inc = 1'b0;
    endcase
    rounded = {1'b0, mag_q} + {{INT_W{1'b0}}, inc};
    pos_max = is_signed_q ? {1'b0, {(INT_W-1){1'b1}}} : {INT_W{1'b1}};
    neg_sat = is_signed_q ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{1'b0}};
    // Signed negatives may reach exactly 2^(INT_W-1); positives may not.
    ovf  = big_q || rounded[INT_W] ||
           (is_signed_q && (op_sign ? (rounded[INT_W-1] && |rounded[INT_W-2:0])
                                    : rounded[INT_W-1]));
    uneg = !is_signed_q && op_sign && |rounded;
    if (state_q == S_ROUND) begin
      out_int_d = '0;
      out_nv_d  = 1'b0;
      out_nx_d  = 1'b0;
      case (cls_q)
        C_NAN: begin
          out_int_d = pos_max;
          out_nv_d  = 1'b1;
        end
        C_INF: begin
          out_int_d = op_sign ? neg_sat : pos_max;
          out_nv_d  = 1'b1;
        end
        C_ZERO: ;
        default: begin
          if (ovf || uneg) begin
            out_int_d = op_sign ? neg_sat : pos_max;
            out_nv_d  = 1'b1;
          end else begin
            out_int_d = op_sign ? -rounded[INT_W-1:0] : rounded[INT_W-1:0];
            out_nx_d  = rnd_q | stk_q;
          end
        end
      endcase
    end
  end

  // NOTE: operand and intermediate registers are reset too, so nothing is X after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= '0;
      rm_q        <= '0;
      is_signed_q <= 1'b0;
      cls_q       <= C_ZERO;
      sig_q       <= '0;
      exp_q       <= '0;
      mag_q       <= '0;
      rnd_q       <= 1'b0;
      stk_q       <= 1'b0;
      big_q       <= 1'b0;
      out_int_q   <= '0;
      out_nv_q    <= 1'b0;
      out_nx_q    <= 1'b0;
    end else begin
      op_q        <= op_d;
      rm_q        <= rm_d;
      is_signed_q <= is_signed_d;
      cls_q       <= cls_d;
      sig_q       <= sig_d;
      exp_q       <= exp_d;
      mag_q       <= mag_d;
      rnd_q       <= rnd_d;
      stk_q       <= stk_d;
      big_q       <= big_d;
      out_int_q   <= out_int_d;
      out_nv_q    <= out_nv_d;
      out_nx_q    <= out_nx_d;
    end
  end

endmodule
